// File: rtl/tank_cmd_sequencer.sv
// Command sequencer in front of the tank storage block.
// Move, fire and projectile-step operations: about 6 cycles from request to ack, one storage access per cycle.
// Requests that arrive while busy stay pending until served. Ports: clk/reset, p1/p2 move/fire requests,
//   st_q read-back, st_* storage controls, p1/p2 acks, cmd_err, proj_active, busy.
module tank_cmd_sequencer #(
  parameter int unsigned PROJ_PERIOD = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_move_req,
  input  logic [7:0] p1_move_dir,
  input  logic       p1_fire_req,
  input  logic       p2_move_req,
  input  logic [7:0] p2_move_dir,
  input  logic       p2_fire_req,
  input  logic [7:0] st_q,
  output logic [3:0] st_mode,
  output logic       st_wren,
  output logic       st_load_out,
  output logic [7:0] st_address,
  output logic [7:0] st_data,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic       cmd_err,
  output logic [1:0] proj_active,
  output logic       busy
);

  localparam logic [7:0] DIR_UP    = 8'h00;
  localparam logic [7:0] DIR_DOWN  = 8'h01;
  localparam logic [7:0] DIR_LEFT  = 8'h03;
  localparam logic [7:0] DIR_RIGHT = 8'h07;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAITQ, S_CAPT, S_WR1, S_WR2} state_t;
  typedef enum logic [1:0] {OP_MOVE, OP_FIRE, OP_STEP} op_t;

  function automatic logic dir_ok(input logic [7:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

  // Positions are {col,row}. A projectile standing on the edge it is heading for leaves the field.
  function automatic logic at_edge(input logic [7:0] pos, input logic [7:0] dir);
    logic e;
    case (dir)
      DIR_UP:    e = (pos[3:0] == 4'h0);
      DIR_DOWN:  e = (pos[3:0] == 4'hF);
      DIR_LEFT:  e = (pos[7:4] == 4'h0);
      DIR_RIGHT: e = (pos[7:4] == 4'hF);
      default:   e = 1'b1;
    endcase
    return e;
  endfunction

  state_t          state_q;
  op_t             op_q;
  logic            plr_q;
  logic [7:0]      dir_q;
  logic [7:0]      pos_q;
  logic            rr_q;
  logic [CNT_W-1:0] tick_q;
  logic [1:0]      pmove_q, pmove_d;
  logic [1:0]      pfire_q, pfire_d;
  logic [1:0]      pstep_q, pstep_d;
  logic [1:0][7:0] pdir_q, pdir_d;
  logic [1:0][7:0] lastdir_q;
  logic [1:0][7:0] projdir_q;

  logic            tick_wrap;
  logic [1:0]      has_cmd;
  logic            gnt_vld;
  op_t             gnt_op;
  logic            gnt_plr;
  logic            gnt_take;
  logic [1:0]      move_req, fire_req, move_ok;
  logic [1:0][7:0] dir_in;

  assign tick_wrap = (tick_q == CNT_W'(PROJ_PERIOD - 1));
  assign move_req  = {p2_move_req, p1_move_req};
  assign fire_req  = {p2_fire_req, p1_fire_req};
  assign dir_in    = {p2_move_dir, p1_move_dir};
  assign move_ok   = {dir_ok(p2_move_dir), dir_ok(p1_move_dir)};
  assign has_cmd   = pmove_q | pfire_q;
  assign gnt_take  = (state_q == S_IDLE) && gnt_vld;

  // Projectile steps beat player commands; players alternate via rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_op  = OP_MOVE;
    gnt_plr = 1'b0;
    if (pstep_q[0]) begin
      gnt_vld = 1'b1; gnt_op = OP_STEP; gnt_plr = 1'b0;
    end else if (pstep_q[1]) begin
      gnt_vld = 1'b1; gnt_op = OP_STEP; gnt_plr = 1'b1;
    end else if (has_cmd[rr_q]) begin
      gnt_vld = 1'b1; gnt_plr = rr_q;
      gnt_op  = pmove_q[rr_q] ? OP_MOVE : OP_FIRE;
    end else if (has_cmd[~rr_q]) begin
      gnt_vld = 1'b1; gnt_plr = ~rr_q;
      gnt_op  = pmove_q[~rr_q] ? OP_MOVE : OP_FIRE;
    end
  end

  // Pending flags: the grant clears first so a request arriving in the same cycle is kept.
  always_comb begin
    pmove_d = pmove_q;
    pfire_d = pfire_q;
    pstep_d = pstep_q;
    pdir_d  = pdir_q;
    if (gnt_take) begin
      case (gnt_op)
        OP_MOVE: pmove_d[gnt_plr] = 1'b0;
        OP_FIRE: pfire_d[gnt_plr] = 1'b0;
        default: pstep_d[gnt_plr] = 1'b0;
      endcase
    end
    for (int p = 0; p < 2; p++) begin
      if (move_req[p] && move_ok[p]) begin
        pmove_d[p] = 1'b1;
        pdir_d[p]  = dir_in[p];
      end
      if (fire_req[p]) pfire_d[p] = 1'b1;
      if (tick_wrap && proj_active[p]) pstep_d[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MOVE;
      plr_q       <= 1'b0;
      dir_q       <= '0;
      pos_q       <= '0;
      rr_q        <= 1'b0;
      tick_q      <= '0;
      pmove_q     <= '0;
      pfire_q     <= '0;
      pstep_q     <= '0;
      pdir_q      <= '0;
      lastdir_q   <= {DIR_UP, DIR_DOWN};
      projdir_q   <= '0;
      st_mode     <= '0;
      st_wren     <= 1'b0;
      st_load_out <= 1'b0;
      st_address  <= '0;
      st_data     <= '0;
      p1_ack      <= 1'b0;
      p2_ack      <= 1'b0;
      cmd_err     <= 1'b0;
      proj_active <= '0;
      busy        <= 1'b0;
    end else begin
      tick_q      <= tick_wrap ? '0 : tick_q + CNT_W'(1);
      pmove_q     <= pmove_d;
      pfire_q     <= pfire_d;
      pstep_q     <= pstep_d;
      pdir_q      <= pdir_d;
      st_wren     <= 1'b0;
      st_load_out <= 1'b0;
      p1_ack      <= 1'b0;
      p2_ack      <= 1'b0;
      cmd_err     <= |(move_req & ~move_ok);

      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            op_q        <= gnt_op;
            plr_q       <= gnt_plr;
            dir_q       <= pdir_q[gnt_plr];
            state_q     <= S_LOAD;
            busy        <= 1'b1;
            st_load_out <= 1'b1;
            if (gnt_op == OP_STEP) st_mode <= gnt_plr ? 4'd6 : 4'd3;
            else                   st_mode <= gnt_plr ? 4'd4 : 4'd1;
          end
        end
        S_LOAD:  state_q <= S_WAITQ;
        S_WAITQ: state_q <= S_CAPT;
        S_CAPT: begin
          pos_q   <= st_q;
          state_q <= S_WR1;
          if (op_q == OP_MOVE) begin
            st_wren <= 1'b1;
            st_mode <= plr_q ? 4'd5 : 4'd2;
            st_data <= dir_q;
          end
        end
        S_WR1: begin
          state_q <= S_WR2;
          case (op_q)
            OP_MOVE: begin
              st_wren          <= 1'b1;
              st_mode          <= plr_q ? 4'd4 : 4'd1;
              st_address       <= pos_q;
              st_data          <= dir_q;
              lastdir_q[plr_q] <= dir_q;
            end
            OP_FIRE: begin
              if (!proj_active[plr_q]) begin
                st_wren            <= 1'b1;
                st_mode            <= plr_q ? 4'd6 : 4'd3;
                st_address         <= pos_q;
                st_data            <= lastdir_q[plr_q];
                proj_active[plr_q] <= 1'b1;
                projdir_q[plr_q]   <= lastdir_q[plr_q];
              end
            end
            default: begin
              // A step queued just as the projectile left is dropped without a write.
              if (proj_active[plr_q] && !at_edge(pos_q, projdir_q[plr_q])) begin
                st_wren    <= 1'b1;
                st_mode    <= plr_q ? 4'd6 : 4'd3;
                st_address <= pos_q;
                st_data    <= projdir_q[plr_q];
              end else begin
                proj_active[plr_q] <= 1'b0;
              end
            end
          endcase
          if (op_q != OP_STEP) begin
            if (plr_q) p2_ack <= 1'b1;
            else       p1_ack <= 1'b1;
            rr_q <= ~rr_q;
          end
        end
        S_WR2: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tank_cmd_sequencer.sv
// Directed bench for tank_cmd_sequencer with a behavioural storage model.
module tb_tank_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       p1_move_req, p1_fire_req, p2_move_req, p2_fire_req;
  logic [7:0] p1_move_dir, p2_move_dir;
  logic [7:0] st_q;
  logic [3:0] st_mode;
  logic       st_wren, st_load_out;
  logic [7:0] st_address, st_data;
  logic       p1_ack, p2_ack, cmd_err, busy;
  logic [1:0] proj_active;

  int n_chk  = 0;
  int n_fail = 0;

  tank_cmd_sequencer #(.PROJ_PERIOD(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .p1_move_req(p1_move_req), .p1_move_dir(p1_move_dir), .p1_fire_req(p1_fire_req),
    .p2_move_req(p2_move_req), .p2_move_dir(p2_move_dir), .p2_fire_req(p2_fire_req),
    .st_q(st_q), .st_mode(st_mode), .st_wren(st_wren), .st_load_out(st_load_out),
    .st_address(st_address), .st_data(st_data), .p1_ack(p1_ack), .p2_ack(p2_ack),
    .cmd_err(cmd_err), .proj_active(proj_active), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: q appears two cycles after the load strobe; pos/proj writes move the
  // addressed position one square in the data direction, clamped at the field border.
  function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic [7:0] dir);
    logic [3:0] c, r;
    c = pos[7:4];
    r = pos[3:0];
    case (dir)
      8'h00: if (r != 4'h0) r = r - 4'd1;
      8'h01: if (r != 4'hF) r = r + 4'd1;
      8'h03: if (c != 4'h0) c = c - 4'd1;
      8'h07: if (c != 4'hF) c = c + 4'd1;
      default: ;
    endcase
    return {c, r};
  endfunction

  logic [7:0] mem [0:7];
  logic [7:0] q_pipe;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= 8'h00; mem[1] <= 8'h22; mem[2] <= 8'h01; mem[3] <= 8'h00;
      mem[4] <= 8'h66; mem[5] <= 8'h00; mem[6] <= 8'h00; mem[7] <= 8'h00;
      q_pipe <= 8'h00;
      st_q   <= 8'h00;
    end else begin
      if (st_load_out) q_pipe <= mem[st_mode[2:0]];
      st_q <= q_pipe;
      if (st_wren) begin
        if (st_mode == 4'd2 || st_mode == 4'd5) mem[st_mode[2:0]] <= st_data;
        else                                    mem[st_mode[2:0]] <= step_pos(st_address, st_data);
      end
    end
  end

  int         w3_cnt = 0, w6_cnt = 0, a1_cnt = 0, a2_cnt = 0;
  logic [7:0] w3_addr = 8'h00, w3_data = 8'h00, w6_addr = 8'h00, w6_data = 8'h00;

  always @(posedge clk) begin
    if (st_wren && st_mode == 4'd3) begin w3_cnt <= w3_cnt + 1; w3_addr <= st_address; w3_data <= st_data; end
    if (st_wren && st_mode == 4'd6) begin w6_cnt <= w6_cnt + 1; w6_addr <= st_address; w6_data <= st_data; end
    if (p1_ack) a1_cnt <= a1_cnt + 1;
    if (p2_ack) a2_cnt <= a2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, st_mode, 0);
    chk({tag, "_wren"}, st_wren, 0);
    chk({tag, "_load"}, st_load_out, 0);
    chk({tag, "_addr"}, st_address, 0);
    chk({tag, "_data"}, st_data, 0);
    chk({tag, "_acks"}, {p1_ack, p2_ack}, 0);
    chk({tag, "_err"}, cmd_err, 0);
    chk({tag, "_proj"}, proj_active, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Per-cycle snapshots, index k = k-th cycle after the request was sampled.
  logic       s_busy [1:16];
  logic       s_load [1:16];
  logic       s_wren [1:16];
  logic       s_a1   [1:16];
  logic       s_a2   [1:16];
  logic [3:0] s_mode [1:16];
  logic [7:0] s_addr [1:16];
  logic [7:0] s_data [1:16];

  task automatic snap_run(input int n);
    for (int k = 1; k <= n; k++) begin
      s_busy[k] = busy; s_load[k] = st_load_out; s_wren[k] = st_wren;
      s_a1[k] = p1_ack; s_a2[k] = p2_ack;
      s_mode[k] = st_mode; s_addr[k] = st_address; s_data[k] = st_data;
      @(negedge clk);
    end
  endtask

  // Leaves the caller on the negedge where the chosen ack is high.
  task automatic wait_ack(input bit p2, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((p2 ? p2_ack : p1_ack) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_proj_clear(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (proj_active[idx] === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  int  a1_0, a2_0, w3_0, w6_0, first1, first2;
  bit  ok;
  logic busy_seen;

  initial begin
    reset = 1'b0;
    p1_move_req = 0; p1_fire_req = 0; p2_move_req = 0; p2_fire_req = 0;
    p1_move_dir = 8'h00; p2_move_dir = 8'h00;
    #12;
    chk_zero("reset");
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    // p1 move down, tank 1 at 8'h22
    p1_move_dir = 8'h01; p1_move_req = 1;
    @(negedge clk); p1_move_req = 0;
    snap_run(8);
    chk("t1_load_k2", s_load[2], 1);
    chk("t1_mode_k2", s_mode[2], 1);
    chk("t1_busy_k2", s_busy[2], 1);
    chk("t1_load_k3", s_load[3], 0);
    chk("t1_wren_k4", s_wren[4], 0);
    chk("t1_wr1", {s_wren[5], s_mode[5], s_data[5]}, {1'b1, 4'd2, 8'h01});
    chk("t1_wr2", {s_wren[6], s_mode[6], s_addr[6], s_data[6]}, {1'b1, 4'd1, 8'h22, 8'h01});
    chk("t1_ack_k5", s_a1[5], 0);
    chk("t1_ack_k6", s_a1[6], 1);
    chk("t1_ack_k7", s_a1[7], 0);
    chk("t1_busy_k6", s_busy[6], 1);
    chk("t1_busy_k7", s_busy[7], 0);
    chk("t1_wren_k7", s_wren[7], 0);

    // illegal direction
    a1_0 = a1_cnt;
    p1_move_dir = 8'h05; p1_move_req = 1;
    @(negedge clk); p1_move_req = 0;
    chk("t5_err", cmd_err, 1);
    @(negedge clk);
    chk("t5_err_drop", cmd_err, 0);
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin busy_seen = busy_seen | busy; @(negedge clk); end
    chk("t5_busy", busy_seen, 0);
    chk("t5_noack", a1_cnt - a1_0, 0);

    // p2 fire from 8'h66 with reset direction up
    w6_0 = w6_cnt; a2_0 = a2_cnt;
    p2_fire_req = 1;
    @(negedge clk); p2_fire_req = 0;
    wait_ack(1'b1, 20, ok);
    chk("t3_ack_seen", ok, 1);
    chk("t3_wr2", {st_wren, st_mode, st_address, st_data}, {1'b1, 4'd6, 8'h66, 8'h00});
    chk("t3_proj", proj_active, 2'b10);
    @(negedge clk);
    p2_fire_req = 1;
    @(negedge clk); p2_fire_req = 0;
    wait_ack(1'b1, 40, ok);
    chk("t3_ack2_seen", ok, 1);
    chk("t3_ack2_nowr", st_wren, 0);
    wait_proj_clear(1, 400, ok);
    chk("t3_cleared", ok, 1);
    @(negedge clk);
    chk("t3_acks", a2_cnt - a2_0, 2);
    chk("t3_wr6_cnt", w6_cnt - w6_0, 6);
    chk("t3_wr6_last", {w6_addr, w6_data}, {8'h61, 8'h00});

    // p1 fire: tank 1 now at 8'h23, last moved down
    w3_0 = w3_cnt;
    p1_fire_req = 1;
    @(negedge clk); p1_fire_req = 0;
    wait_ack(1'b0, 40, ok);
    chk("t4_ack_seen", ok, 1);
    chk("t4_wr2", {st_wren, st_mode, st_address, st_data}, {1'b1, 4'd3, 8'h23, 8'h01});
    chk("t4_proj", proj_active, 2'b01);
    wait_proj_clear(0, 600, ok);
    chk("t4_cleared", ok, 1);
    @(negedge clk);
    chk("t4_wr3_cnt", w3_cnt - w3_0, 12);
    chk("t4_wr3_last", {w3_addr, w3_data}, {8'h2E, 8'h01});

    // fresh reset, simultaneous moves
    reset = 1'b0;
    #1;
    chk_zero("reset2");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    p1_move_dir = 8'h07; p2_move_dir = 8'h03;
    p1_move_req = 1; p2_move_req = 1;
    @(negedge clk); p1_move_req = 0; p2_move_req = 0;
    snap_run(14);
    first1 = 0; first2 = 0;
    for (int k = 14; k >= 1; k--) begin
      if (s_a1[k]) first1 = k;
      if (s_a2[k]) first2 = k;
    end
    chk("t2_p1_ack_cyc", first1, 6);
    chk("t2_p2_ack_cyc", first2, 12);
    chk("t2_p1_wr2", {s_mode[6], s_addr[6], s_data[6]}, {4'd1, 8'h22, 8'h07});
    chk("t2_p2_wr2", {s_mode[12], s_addr[12], s_data[12]}, {4'd4, 8'h66, 8'h03});

    // reset in the middle of a transaction
    a1_0 = a1_cnt;
    p1_move_dir = 8'h00; p1_move_req = 1;
    @(negedge clk); p1_move_req = 0;
    @(negedge clk); @(negedge clk);
    chk("t6_busy_waitq", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk_zero("t6_rst");
    #1 reset = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); busy_seen = busy_seen | busy; end
    chk("t6_noack", a1_cnt - a1_0, 0);
    chk("t6_idle", busy_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
